// File: rtl/ins_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface ins_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC sequencing, imem handshake, decode hand-off, ack timeout.
// Optional one-entry skid buffer for transfers landing during stall: macro FETCH_SKID_EN.
module ins_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  ins_fetch_if.master       imem,
  output logic [31:0]       insDecode_pc,
  output logic [31:0]       insDecode_ins,
  output logic              ins_valid,
  output logic              imem_timeout
);

  typedef enum logic [0:0] {FETCH, SKID_FULL} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic        started;
  logic [7:0]  ack_cnt;
  logic [8:0]  cnt_inc;
  logic        transfer;
  logic        load_fetch;
  logic        load_bubble;
`ifdef FETCH_SKID_EN
  logic        load_skid;
  logic        skid_wr;
  logic [31:0] skid_pc;
  logic [31:0] skid_ins;
`endif

  assign imem.imem_addr = pc & 32'hFFFF_FFFC;
  assign cnt_inc        = {1'b0, ack_cnt} + 9'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_fetch    = 1'b0;
    load_bubble   = 1'b0;
`ifdef FETCH_SKID_EN
    load_skid     = 1'b0;
    skid_wr       = 1'b0;
    imem.imem_req = started && (state == FETCH);
`else
    imem.imem_req = started && (state == FETCH) && !stall;
`endif
    transfer      = imem.imem_req && imem.imem_ack;
    if (branch_flag) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            load_fetch  = transfer;
            load_bubble = !transfer;
          end
`ifdef FETCH_SKID_EN
          else if (transfer) begin
            skid_wr    = 1'b1;
            state_next = SKID_FULL;
          end
`endif
        end
        SKID_FULL: begin
`ifdef FETCH_SKID_EN
          if (!stall) begin
            load_skid  = 1'b1;
            state_next = FETCH;
          end
`else
          state_next = FETCH;
`endif
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // Branch wins over everything: redirect pc and drop any transfer this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (branch_flag)   pc <= branch_target & 32'hFFFF_FFFC;
      else if (transfer) pc <= imem.imem_addr + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insDecode_pc  <= '0;
      insDecode_ins <= '0;
      ins_valid     <= 1'b0;
    end else if (branch_flag) begin
      insDecode_ins <= '0;
      ins_valid     <= 1'b0;
    end else if (load_fetch) begin
      insDecode_pc  <= imem.imem_addr;
      insDecode_ins <= imem.imem_data;
      ins_valid     <= 1'b1;
    end else if (load_bubble) begin
      insDecode_ins <= '0;
      ins_valid     <= 1'b0;
    end
`ifdef FETCH_SKID_EN
    else if (load_skid) begin
      insDecode_pc  <= skid_pc;
      insDecode_ins <= skid_ins;
      ins_valid     <= 1'b1;
    end
`endif
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_pc  <= '0;
      skid_ins <= '0;
    end else if (skid_wr) begin
      skid_pc  <= imem.imem_addr;
      skid_ins <= imem.imem_data;
    end
  end
`endif

  // Counter saturates so a long outage cannot wrap back below the threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_cnt      <= '0;
      imem_timeout <= 1'b0;
    end else if (branch_flag || transfer) begin
      ack_cnt <= '0;
    end else if (imem.imem_req && !imem.imem_ack) begin
      if (ack_cnt != '1) ack_cnt <= cnt_inc[7:0];
      if (cnt_inc >= {1'b0, ACK_TIMEOUT}) imem_timeout <= 1'b1;
    end
  end

endmodule
